// File: rtl/fetch_unit.sv
// Instruction fetch controller: one outstanding request at a time, feeding a
// downstream instruction buffer as {pc, instr} records, with backend redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        buf_full,
    output logic        write_en,
    output logic [63:0] write_data,
    output logic [31:0] fetch_count
);

    // state | meaning
    // IDLE  | just out of reset, moves to FETCH on the first edge
    // FETCH | present request at pc until memory accepts it
    // WAIT  | request outstanding, waiting for the response
    // WRITE | single cycle pushing the captured record downstream
    // DRAIN | redirected while outstanding; discard the stale response
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            wdata_q <= 64'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        wdata_d        = wdata_q;
        imem_req_valid = 1'b0;
        write_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_valid = !buf_full && !redirect_valid;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = imem_resp_valid ? S_FETCH : S_DRAIN;
                end else if (imem_resp_valid) begin
                    wdata_d = {pc_q, imem_resp_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                write_en = !redirect_valid;
                pc_d     = redirect_valid ? redirect_pc : pc_q + 32'd4;
                state_d  = S_FETCH;
            end
            S_DRAIN: begin
                // a same-cycle response retires the outstanding request
                if (redirect_valid) pc_d = redirect_pc;
                if (imem_resp_valid) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        count_d = write_en ? count_q + 32'd1 : count_q;
    end

    assign imem_req_addr = pc_q;
    assign write_data    = wdata_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset and
// PC-wrap sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_ready, resp_valid, redir, full;
    logic [31:0] resp_data, redir_pc;

    logic        d0_rv, d0_we, d1_rv, d1_we;
    logic [31:0] d0_addr, d0_cnt, d1_addr, d1_cnt;
    logic [63:0] d0_wd, d1_wd;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(d0_rv), .imem_req_addr(d0_addr), .imem_req_ready(req_ready),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc), .buf_full(full),
        .write_en(d0_we), .write_data(d0_wd), .fetch_count(d0_cnt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(d1_rv), .imem_req_addr(d1_addr), .imem_req_ready(req_ready),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc), .buf_full(full),
        .write_en(d1_we), .write_data(d1_wd), .fetch_count(d1_cnt)
    );

    typedef struct {
        logic        ready;
        logic        respv;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        full;
        logic        erv;
        logic [31:0] eaddr;
        logic        ewe;
        logic [63:0] ewd;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I0 = 32'h1111_0001;
    localparam logic [31:0] I1 = 32'h1111_0002;
    localparam logic [31:0] I2 = 32'h1111_0003;
    localparam logic [31:0] I3 = 32'hDEAD_BEEF;
    localparam logic [31:0] I4 = 32'h2222_0004;
    localparam logic [31:0] I5 = 32'h3333_0005;

    function automatic void add(input logic rdy, input logic rv, input logic [31:0] dat,
                                input logic rd, input logic [31:0] rpc, input logic fl,
                                input logic erv, input logic [31:0] eaddr, input logic ewe,
                                input logic [63:0] ewd, input logic [31:0] ecnt);
        vec_t v;
        v.ready = rdy; v.respv = rv; v.data = dat; v.redir = rd; v.rpc = rpc; v.full = fl;
        v.erv = erv; v.eaddr = eaddr; v.ewe = ewe; v.ewd = ewd; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_ready = 1'b1; resp_valid = 1'b0; resp_data = 32'h0;
        redir = 1'b0; redir_pc = 32'h0; full = 1'b0;
    endtask

    initial begin
        bit found;

        // basic streaming, one write every 3 cycles
        add(1,0,0 ,0,0,0, 0,32'h0,0,64'h0,0);
        add(1,0,0 ,0,0,0, 1,32'h0,0,64'h0,0);
        add(1,1,I0,0,0,0, 0,32'h0,0,64'h0,0);
        add(1,0,0 ,0,0,0, 0,32'h0,1,{32'h0,I0},0);
        add(1,0,0 ,0,0,0, 1,32'h4,0,64'h0,1);
        add(1,1,I1,0,0,0, 0,32'h4,0,64'h0,1);
        add(1,0,0 ,0,0,0, 0,32'h4,1,{32'h4,I1},1);
        add(1,0,0 ,0,0,0, 1,32'h8,0,64'h0,2);
        add(1,1,I2,0,0,0, 0,32'h8,0,64'h0,2);
        add(1,0,0 ,0,0,0, 0,32'h8,1,{32'h8,I2},2);
        // buffer full for 10 cycles holds FETCH
        for (int k = 0; k < 10; k++) add(1,0,0,0,0,1, 0,32'hC,0,64'h0,3);
        add(1,0,0 ,0,0,0, 1,32'hC,0,64'h0,3);
        // redirect together with response in WAIT
        add(1,1,I3,1,32'h100,0, 0,32'hC,0,64'h0,3);
        add(1,0,0 ,0,0,0, 1,32'h100,0,64'h0,3);
        // redirect in WAIT, late response drained
        add(1,0,0 ,1,32'h200,0, 0,32'h100,0,64'h0,3);
        add(1,0,0 ,0,0,0, 0,32'h200,0,64'h0,3);
        add(1,1,I3,0,0,0, 0,32'h200,0,64'h0,3);
        add(1,0,0 ,0,0,0, 1,32'h200,0,64'h0,3);
        add(1,1,I4,0,0,0, 0,32'h200,0,64'h0,3);
        // redirect during WRITE
        add(1,0,0 ,1,32'h300,0, 0,32'h200,0,64'h0,3);
        add(0,0,0 ,0,0,0, 1,32'h300,0,64'h0,3);
        add(1,0,0 ,0,0,0, 1,32'h300,0,64'h0,3);
        add(1,1,I5,0,0,0, 0,32'h300,0,64'h0,3);
        add(1,0,0 ,0,0,0, 0,32'h300,1,{32'h300,I5},3);
        // redirect in FETCH
        add(1,0,0 ,1,32'h400,0, 0,32'h304,0,64'h0,4);
        add(1,0,0 ,0,0,0, 1,32'h400,0,64'h0,4);
        // repeated redirects in DRAIN, last one with the response
        add(1,0,0 ,1,32'h500,0, 0,32'h400,0,64'h0,4);
        add(1,0,0 ,1,32'h600,0, 0,32'h500,0,64'h0,4);
        add(1,1,I3,1,32'h700,0, 0,32'h600,0,64'h0,4);
        add(0,0,0 ,0,0,0, 1,32'h700,0,64'h0,4);

        idle_inputs();
        reset = 1'b1;
        #1;
        check("rst_rv",   d0_rv,   1'b0);
        check("rst_we",   d0_we,   1'b0);
        check("rst_addr", d0_addr, 32'h0);
        check("rst_cnt",  d0_cnt,  32'h0);
        check("rst_wd",   d0_wd,   64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            req_ready  = vecs[i].ready;
            resp_valid = vecs[i].respv;
            resp_data  = vecs[i].data;
            redir      = vecs[i].redir;
            redir_pc   = vecs[i].rpc;
            full       = vecs[i].full;
            #1;
            check($sformatf("v%0d_rv", i),   d0_rv,   vecs[i].erv);
            check($sformatf("v%0d_addr", i), d0_addr, vecs[i].eaddr);
            check($sformatf("v%0d_we", i),   d0_we,   vecs[i].ewe);
            check($sformatf("v%0d_cnt", i),  d0_cnt,  vecs[i].ecnt);
            if (vecs[i].ewe) check($sformatf("v%0d_wd", i), d0_wd, vecs[i].ewd);
            @(negedge clk);
        end

        // async reset while a request is outstanding; stale response ignored
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rv",   d0_rv,   1'b0);
        check("async_addr", d0_addr, 32'h0);
        check("async_cnt",  d0_cnt,  32'h0);
        check("async_wd",   d0_wd,   64'h0);
        @(negedge clk);
        reset = 1'b0;
        resp_valid = 1'b1;
        resp_data  = I3;
        #1;
        check("stale_we", d0_we, 1'b0);
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        check("stale_rv",   d0_rv,   1'b1);
        check("stale_addr", d0_addr, 32'h0);
        check("stale_we2",  d0_we,   1'b0);
        @(negedge clk);
        #1;
        check("stale_cnt", d0_cnt, 32'h0);

        // PC wrap from 0xFFFF_FFFC
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            #1;
            if (d1_rv) found = 1'b1;
            else @(negedge clk);
        end
        check("wrap_req_seen", found, 1'b1);
        check("wrap_addr0", d1_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = I4;
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        check("wrap_we", d1_we, 1'b1);
        check("wrap_wd", d1_wd, {32'hFFFF_FFFC, I4});
        @(negedge clk);
        #1;
        check("wrap_rv",   d1_rv,   1'b1);
        check("wrap_addr", d1_addr, 32'h0);
        check("wrap_cnt",  d1_cnt,  32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
